// File: rtl/nand_target_if.sv
// NAND pin bundle between a controller (master) and the device responder (slave).
interface nand_target_if;
  logic       F_nCE;
  logic       F_CLE;
  logic       F_ALE;
  logic       F_nWE;
  logic       F_nRE;
  logic       F_nWP;
  logic [7:0] F_DIO_I;
  logic       F_nRB;
  logic [7:0] F_DIO_O;
  logic       F_DIO_OE;

  modport master (
    output F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_I,
    input  F_nRB, F_DIO_O, F_DIO_OE
  );

  modport slave (
    input  F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, F_DIO_I,
    output F_nRB, F_DIO_O, F_DIO_OE
  );
endinterface

// File: rtl/nand_target.sv
// NAND flash device responder: decodes nWE cycles, holds a small page array,
// drives R/B# busy windows and returns page data or status on nRE falls.
module nand_target #(
  parameter int PAGE_BYTES = 16,
  parameter int PAGES      = 8,
  parameter int T_RD       = 8,
  parameter int T_PROG     = 32,
  parameter int T_ERS      = 64,
  parameter int T_RST      = 4
) (
  input  logic         PCLK,
  input  logic         PRESETN,
  nand_target_if.slave bus,
  output logic [2:0]   dbg_state
);
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(PAGES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_RD_CONF = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_ER_ADDR = 3'd4;
  localparam logic [2:0] S_BUSY    = 3'd5;
  localparam logic [2:0] S_DOUT    = 3'd6;
  localparam logic [2:0] S_SOUT    = 3'd7;

  logic [2:0]    state;
  logic          nwe_q, nre_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    addr_cnt;
  logic          prog_mode, fail, busy_to_dout;
  logic [15:0]   busy_cnt;
  logic          wr_active, wr_erase;
  logic [CW-1:0] wr_idx;
  logic [7:0]    dio_o;
  logic          dio_oe;
  logic [7:0]    mem  [PAGES][PAGE_BYTES];
  logic [7:0]    pbuf [PAGE_BYTES];

  logic       we_rise, re_fall, is_cmd, is_addr, is_data, busy;
  logic       data_wr, rd_load;
  logic [7:0] status;

  always_comb begin
    we_rise = ~nwe_q & bus.F_nWE & ~bus.F_nCE;
    re_fall = nre_q & ~bus.F_nRE & ~bus.F_nCE;
    is_cmd  = bus.F_CLE & ~bus.F_ALE;
    is_addr = ~bus.F_CLE & bus.F_ALE;
    is_data = ~bus.F_CLE & ~bus.F_ALE;
    busy    = (busy_cnt != 16'd0);
    status  = {bus.F_nWP, ~busy, ~busy, 4'b0000, fail};
    data_wr = we_rise & is_data & ~busy &
              ((state == S_WR_DATA) || ((state == S_ADDR) && prog_mode));
    rd_load = we_rise & is_cmd & ~busy & (bus.F_DIO_I == 8'h30) &
              ((state == S_ADDR) || (state == S_RD_CONF));
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state        <= S_IDLE;
      nwe_q        <= 1'b1;
      nre_q        <= 1'b1;
      col          <= '0;
      row          <= '0;
      addr_cnt     <= 3'd0;
      prog_mode    <= 1'b0;
      fail         <= 1'b0;
      busy_to_dout <= 1'b0;
      busy_cnt     <= 16'd0;
      wr_active    <= 1'b0;
      wr_erase     <= 1'b0;
      wr_idx       <= '0;
      dio_o        <= 8'h00;
      dio_oe       <= 1'b0;
    end else begin
      nwe_q  <= bus.F_nWE;
      nre_q  <= bus.F_nRE;
      dio_oe <= ~bus.F_nCE & ~bus.F_nRE & bus.F_nWE &
                ((state == S_DOUT) || (state == S_SOUT));

      // Busy timing runs independently of the state so 70h can peek at status.
      if (busy) begin
        busy_cnt <= busy_cnt - 16'd1;
        if ((busy_cnt == 16'd1) && (state == S_BUSY))
          state <= busy_to_dout ? S_DOUT : S_IDLE;
      end

      if (wr_active) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == CW'(PAGE_BYTES - 1)) wr_active <= 1'b0;
      end

      if (we_rise && is_cmd) begin
        if (bus.F_DIO_I == 8'hFF) begin
          state        <= S_BUSY;
          busy_cnt     <= 16'(T_RST);
          busy_to_dout <= 1'b0;
          fail         <= 1'b0;
          wr_active    <= 1'b0;
        end else if (bus.F_DIO_I == 8'h70) begin
          state <= S_SOUT;
        end else if (!busy) begin
          case (bus.F_DIO_I)
            8'h00: begin state <= S_ADDR; addr_cnt <= 3'd0; prog_mode <= 1'b0; end
            8'h80: begin state <= S_ADDR; addr_cnt <= 3'd0; prog_mode <= 1'b1; end
            8'h60: begin state <= S_ER_ADDR; addr_cnt <= 3'd0; end
            8'h30: begin
              if (rd_load) begin
                state        <= S_BUSY;
                busy_cnt     <= 16'(T_RD);
                busy_to_dout <= 1'b1;
              end else state <= S_IDLE;
            end
            8'h10: begin
              if ((state == S_WR_DATA) || ((state == S_ADDR) && prog_mode)) begin
                state        <= S_BUSY;
                busy_to_dout <= 1'b0;
                if (bus.F_nWP) begin
                  busy_cnt  <= 16'(T_PROG);
                  wr_active <= 1'b1;
                  wr_erase  <= 1'b0;
                  wr_idx    <= '0;
                end else begin
                  busy_cnt <= 16'(T_RST);
                  fail     <= 1'b1;
                end
              end else state <= S_IDLE;
            end
            8'hD0: begin
              if (state == S_ER_ADDR) begin
                state        <= S_BUSY;
                busy_to_dout <= 1'b0;
                if (bus.F_nWP) begin
                  busy_cnt  <= 16'(T_ERS);
                  wr_active <= 1'b1;
                  wr_erase  <= 1'b1;
                  wr_idx    <= '0;
                  fail      <= 1'b0;
                end else begin
                  busy_cnt <= 16'(T_RST);
                  fail     <= 1'b1;
                end
              end else state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end else if (we_rise && is_addr && !busy) begin
        if ((state == S_ADDR) && (addr_cnt < 3'd5)) begin
          if (addr_cnt == 3'd0) col <= bus.F_DIO_I[CW-1:0];
          if (addr_cnt == 3'd2) row <= bus.F_DIO_I[RW-1:0];
          addr_cnt <= addr_cnt + 3'd1;
          if ((addr_cnt == 3'd4) && !prog_mode) state <= S_RD_CONF;
        end else if ((state == S_ER_ADDR) && (addr_cnt < 3'd3)) begin
          if (addr_cnt == 3'd0) row <= bus.F_DIO_I[RW-1:0];
          addr_cnt <= addr_cnt + 3'd1;
        end
      end else if (data_wr) begin
        col   <= col + 1'b1;
        state <= S_WR_DATA;
      end

      if (re_fall) begin
        if ((state == S_DOUT) && !busy) begin
          dio_o <= pbuf[col];
          col   <= col + 1'b1;
        end else if (state == S_SOUT) begin
          dio_o <= status;
        end
      end
    end
  end

  // Storage is deliberately unreset; the array behaves like real flash contents.
  always_ff @(posedge PCLK) begin
    if (rd_load) begin
      for (int i = 0; i < PAGE_BYTES; i++) pbuf[i] <= mem[row][i];
    end else if (data_wr) begin
      pbuf[col] <= bus.F_DIO_I;
    end
    if (wr_active)
      mem[row][wr_idx] <= wr_erase ? 8'hFF : (mem[row][wr_idx] & pbuf[wr_idx]);
  end

  assign bus.F_nRB    = ~busy;
  assign bus.F_DIO_O  = dio_o;
  assign bus.F_DIO_OE = dio_oe;
  assign dbg_state    = state;
endmodule

// File: tb/tb_nand_target.sv
// Directed + randomized bench for nand_target against a page-level flash model.
module tb_nand_target;
  localparam int PB = 16, NP = 8, T_RD = 8, T_PROG = 32, T_ERS = 64, T_RST = 4;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;

  nand_target_if bus();

  nand_target #(
    .PAGE_BYTES(PB), .PAGES(NP), .T_RD(T_RD), .T_PROG(T_PROG), .T_ERS(T_ERS), .T_RST(T_RST)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Reference model: flash array, page register, FAIL bit, WP pin.
  logic [7:0] m_mem [NP][PB];
  logic [7:0] m_buf [PB];
  logic       m_fail;
  logic       m_wp;
  logic [7:0] pq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(input logic wp, input logic rdy, input logic f);
    return {wp, rdy, rdy, 4'b0000, f};
  endfunction

  task automatic wr_cycle(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge PCLK);
    bus.F_CLE = cle; bus.F_ALE = ale; bus.F_DIO_I = d; bus.F_nWE = 1'b0;
    @(negedge PCLK);
    bus.F_nWE = 1'b1;
    @(negedge PCLK);
  endtask

  task automatic cmd(input logic [7:0] d);  wr_cycle(1'b1, 1'b0, d); endtask
  task automatic addr(input logic [7:0] d); wr_cycle(1'b0, 1'b1, d); endtask
  task automatic data(input logic [7:0] d); wr_cycle(1'b0, 1'b0, d); endtask

  task automatic send_addr5(input int col, input int row);
    addr(8'(col)); addr(8'h00); addr(8'(row)); addr(8'h00); addr(8'h00);
  endtask

  task automatic re_pulse(output logic [7:0] d, output logic oe);
    @(negedge PCLK);
    bus.F_nRE = 1'b0;
    @(negedge PCLK);
    d  = bus.F_DIO_O;
    oe = bus.F_DIO_OE;
    bus.F_nRE = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int c0, input int exp_cycles);
    int g;
    g = 0;
    while (bus.F_nRB !== 1'b1 && g < 5000) begin
      @(negedge PCLK);
      g++;
    end
    chk(tag, 32'(cyc - c0), 32'(exp_cycles));
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    logic oe;
    cmd(8'h70);
    re_pulse(d, oe);
    chk(tag, d, exp_status(m_wp, 1'b1, m_fail));
    chk({tag, "_oe"}, oe, 1'b1);
  endtask

  task automatic do_erase(input int row);
    int c0;
    cmd(8'h60); addr(8'(row)); addr(8'h00); addr(8'h00); cmd(8'hD0);
    c0 = cyc;
    chk("erase_nrb_low", bus.F_nRB, 1'b0);
    wait_ready("erase_busy", c0, m_wp ? T_ERS : T_RST);
    if (m_wp) begin
      for (int i = 0; i < PB; i++) m_mem[row][i] = 8'hFF;
      m_fail = 1'b0;
    end else m_fail = 1'b1;
  endtask

  task automatic do_program(input int row, input int col);
    int c0;
    int c;
    cmd(8'h80);
    send_addr5(col, row);
    foreach (pq[i]) data(pq[i]);
    cmd(8'h10);
    c0 = cyc;
    chk("prog_nrb_low", bus.F_nRB, 1'b0);
    wait_ready("prog_busy", c0, m_wp ? T_PROG : T_RST);
    c = col;
    foreach (pq[i]) begin
      m_buf[c] = pq[i];
      c = (c + 1) % PB;
    end
    if (m_wp) begin
      for (int i = 0; i < PB; i++) m_mem[row][i] = m_mem[row][i] & m_buf[i];
    end else m_fail = 1'b1;
  endtask

  task automatic do_read(input string tag, input int row, input int col, input int n);
    int c0;
    logic [7:0] d;
    logic oe;
    cmd(8'h00);
    send_addr5(col, row);
    cmd(8'h30);
    c0 = cyc;
    wait_ready("read_busy", c0, T_RD);
    for (int i = 0; i < PB; i++) m_buf[i] = m_mem[row][i];
    for (int i = 0; i < n; i++) begin
      re_pulse(d, oe);
      chk(tag, d, m_buf[(col + i) % PB]);
      if (i == 0) chk({tag, "_oe"}, oe, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic oe;
    int c0;
    int row;
    int col;
    int n;

    // Clock/reset and idle pins
    PRESETN = 1'b0;
    bus.F_nCE = 1'b0; bus.F_CLE = 1'b0; bus.F_ALE = 1'b0;
    bus.F_nWE = 1'b1; bus.F_nRE = 1'b1; bus.F_nWP = 1'b1; bus.F_DIO_I = 8'h00;
    m_wp = 1'b1; m_fail = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    @(negedge PCLK);
    chk("rst_nrb", bus.F_nRB, 1'b1);
    chk("rst_oe", bus.F_DIO_OE, 1'b0);
    chk("rst_dio", bus.F_DIO_O, 8'h00);
    chk("rst_state", dbg_state, 3'd0);
    read_status("status_after_reset");

    // Erase row 3 then read back all FFh
    do_erase(3);
    do_read("erase_read", 3, 0, PB);

    // Program 00h..0Fh, read from col 4 with wrap
    pq.delete();
    for (int i = 0; i < PB; i++) pq.push_back(8'(i));
    do_program(3, 0);
    do_read("prog_read_wrap", 3, 4, PB);

    // Program F0h over existing data: bits only clear
    pq.delete();
    for (int i = 0; i < PB; i++) pq.push_back(8'hF0);
    do_program(3, 0);
    do_read("and_read", 3, 0, PB);

    // Write-protected erase
    m_wp = 1'b0; bus.F_nWP = 1'b0;
    do_erase(3);
    read_status("status_wp");
    m_wp = 1'b1; bus.F_nWP = 1'b1;
    read_status("status_fail_kept");
    do_read("wp_unchanged", 3, 0, PB);

    // FFh during program busy truncates; row 6 is then left out of the model
    do_erase(6);
    pq.delete();
    for (int i = 0; i < PB; i++) pq.push_back(8'($urandom_range(0, 255)));
    cmd(8'h80);
    send_addr5(0, 6);
    foreach (pq[i]) data(pq[i]);
    cmd(8'h10);
    foreach (pq[i]) m_buf[i] = pq[i];
    repeat (5) @(negedge PCLK);
    cmd(8'hFF);
    c0 = cyc;
    m_fail = 1'b0;
    wait_ready("ff_busy", c0, T_RST);
    read_status("status_after_ff");

    // 70h during erase busy
    cmd(8'h60); addr(8'h01); addr(8'h00); addr(8'h00); cmd(8'hD0);
    c0 = cyc;
    cmd(8'h70);
    re_pulse(d, oe);
    chk("status_busy", d, exp_status(1'b1, 1'b0, 1'b0));
    chk("nrb_still_low", bus.F_nRB, 1'b0);
    wait_ready("erase_busy_70h", c0, T_ERS);
    for (int i = 0; i < PB; i++) m_mem[1][i] = 8'hFF;
    re_pulse(d, oe);
    chk("status_ready_again", d, exp_status(1'b1, 1'b1, 1'b0));
    do_read("erase1_read", 1, 0, 4);

    // Randomized erase/program/read rounds (row 6 excluded)
    for (int r = 0; r < 4; r++) begin
      row = $urandom_range(0, NP - 1);
      if (row == 6) row = 7;
      col = $urandom_range(0, PB - 1);
      n   = $urandom_range(1, PB);
      do_erase(row);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(8'($urandom_range(0, 255)));
      do_program(row, col);
      do_read("rand_read", row, $urandom_range(0, PB - 1), PB);
    end

    // nCE high: no output enable, data frozen
    d = bus.F_DIO_O;
    @(negedge PCLK);
    bus.F_nCE = 1'b1; bus.F_nRE = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("nce_oe_off", bus.F_DIO_OE, 1'b0);
    chk("nce_dio_frozen", bus.F_DIO_O, d);
    bus.F_nRE = 1'b1;
    @(negedge PCLK);
    bus.F_nCE = 1'b0;

    // Reset in the middle of an erase busy window
    cmd(8'h60); addr(8'h00); addr(8'h00); addr(8'h00); cmd(8'hD0);
    repeat (10) @(negedge PCLK);
    PRESETN = 1'b0;
    #1;
    chk("midbusy_rst_nrb", bus.F_nRB, 1'b1);
    chk("midbusy_rst_state", dbg_state, 3'd0);
    chk("midbusy_rst_dio", bus.F_DIO_O, 8'h00);
    @(negedge PCLK);
    PRESETN = 1'b1;
    m_fail = 1'b0;
    read_status("status_after_midbusy_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
